// File: rtl/dac_ramp_source.sv
// Test-pattern source for the AD56x3 DAC driver: channel A sawtooth, channel B
// triangle, one A/B sample pair per UPDATE_DIV clocks over an Avalon-ST source.
module dac_ramp_source #(
    parameter int    DATA_WIDTH    = 14,
    parameter string SIGN_A        = "UNSIGNED",
    parameter string SIGN_B        = "UNSIGNED",
    parameter int    INCREASE_RATE = 1,
    parameter int    UPDATE_DIV    = 100
) (
    input  logic                  csi_clk,
    input  logic                  rsi_reset,
    input  logic                  coe_genEnable,
    output logic                  aso_gen_valid,
    output logic                  aso_gen_channel,
    output logic [DATA_WIDTH-1:0] aso_gen_data,
    input  logic                  aso_gen_ready,
    output logic                  coe_genOverrun
);

    localparam int W     = DATA_WIDTH;
    localparam int DIV_W = $clog2(UPDATE_DIV);

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(UPDATE_DIV - 1);
    localparam logic [W:0]       STEP_X     = (W+1)'(INCREASE_RATE);
    localparam logic [W:0]       MAX_X      = {1'b0, {W{1'b1}}};
    localparam logic [W-1:0]     SIGN_FLIP  = {1'b1, {(W-1){1'b0}}};
    localparam bit               SIGNED_A   = (SIGN_A == "SIGNED");
    localparam bit               SIGNED_B   = (SIGN_B == "SIGNED");

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SEND_A,
        ST_SEND_B
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [W-1:0]     acc_a;
    logic [W-1:0]     acc_b;
    logic             dir_down;
    logic             pair_done;
    logic [W:0]       acc_b_up;
    logic [W-1:0]     code_a;
    logic [W-1:0]     code_b;

    assign tick     = (div_cnt == '0);
    assign acc_b_up = {1'b0, acc_b} + STEP_X;

    // Signed coding is offset binary: flipping the MSB maps 0 to -2^(W-1).
    assign code_a = SIGNED_A ? (acc_a ^ SIGN_FLIP) : acc_a;
    assign code_b = SIGNED_B ? (acc_b ^ SIGN_FLIP) : acc_b;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge csi_clk) begin
        if (rsi_reset || tick) begin
            div_cnt <= DIV_RELOAD;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next      = state;
        aso_gen_valid   = 1'b0;
        aso_gen_channel = 1'b0;
        aso_gen_data    = '0;
        pair_done       = 1'b0;
        case (state)
            ST_WAIT: begin
                if (tick && coe_genEnable) begin
                    state_next = ST_SEND_A;
                end
            end
            ST_SEND_A: begin
                aso_gen_valid = 1'b1;
                aso_gen_data  = code_a;
                if (aso_gen_ready) begin
                    state_next = ST_SEND_B;
                end
            end
            ST_SEND_B: begin
                aso_gen_valid   = 1'b1;
                aso_gen_channel = 1'b1;
                aso_gen_data    = code_b;
                if (aso_gen_ready) begin
                    state_next = ST_WAIT;
                    pair_done  = 1'b1;
                end
            end
            default: state_next = ST_WAIT;
        endcase
    end

    // Ramps advance only once the whole pair has been accepted downstream.
    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            acc_a    <= '0;
            acc_b    <= '0;
            dir_down <= 1'b0;
        end else if (pair_done) begin
            acc_a <= acc_a + STEP_X[W-1:0];
            if (!dir_down) begin
                if (acc_b_up >= MAX_X) begin
                    acc_b    <= MAX_X[W-1:0];
                    dir_down <= 1'b1;
                end else begin
                    acc_b <= acc_b_up[W-1:0];
                end
            end else begin
                if ({1'b0, acc_b} <= STEP_X) begin
                    acc_b    <= '0;
                    dir_down <= 1'b0;
                end else begin
                    acc_b <= acc_b - STEP_X[W-1:0];
                end
            end
        end
    end

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            coe_genOverrun <= 1'b0;
        end else if (tick && (state != ST_WAIT)) begin
            coe_genOverrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dac_ramp_source.sv
// Bench for dac_ramp_source: two instances (step 1 unsigned; step 3 with signed A)
// checked each cycle against a transaction-level ramp model plus directed scenarios.
module tb_dac_ramp_source;

    localparam int W    = 4;
    localparam int UDIV = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         rdy;
    logic         valid0, valid1;
    logic         chan0, chan1;
    logic [W-1:0] data0, data1;
    logic         ovr0, ovr1;

    always #5 clk = ~clk;

    dac_ramp_source #(
        .DATA_WIDTH(W), .SIGN_A("UNSIGNED"), .SIGN_B("UNSIGNED"),
        .INCREASE_RATE(1), .UPDATE_DIV(UDIV)
    ) dut0 (
        .csi_clk(clk), .rsi_reset(rst), .coe_genEnable(en),
        .aso_gen_valid(valid0), .aso_gen_channel(chan0), .aso_gen_data(data0),
        .aso_gen_ready(rdy), .coe_genOverrun(ovr0)
    );

    dac_ramp_source #(
        .DATA_WIDTH(W), .SIGN_A("SIGNED"), .SIGN_B("UNSIGNED"),
        .INCREASE_RATE(3), .UPDATE_DIV(UDIV)
    ) dut1 (
        .csi_clk(clk), .rsi_reset(rst), .coe_genEnable(en),
        .aso_gen_valid(valid1), .aso_gen_channel(chan1), .aso_gen_data(data1),
        .aso_gen_ready(rdy), .coe_genOverrun(ovr1)
    );

    int tests = 0;
    int fails = 0;

    // Model: samples still owed in the current pair (2 = A next, 1 = B next).
    int m_left = 0;
    int m_n    = 0;
    bit m_ovr  = 1'b0;
    int m_a[2];
    int m_b[2];
    bit m_up[2];

    bit rec = 1'b0;
    int first_valid = -1;
    int ga0[$], gb0[$], ga1[$], gb1[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int step_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int code_of(input int i, input int v, input bit is_b);
        if (i == 1 && !is_b) return v ^ (1 << (W - 1));
        return v;
    endfunction

    task automatic advance_ramps();
        for (int i = 0; i < 2; i++) begin
            int s;
            s = step_of(i);
            m_a[i] = (m_a[i] + s) % (MAXV + 1);
            if (m_up[i]) begin
                if (m_b[i] + s >= MAXV) begin m_b[i] = MAXV; m_up[i] = 1'b0; end
                else m_b[i] = m_b[i] + s;
            end else begin
                if (m_b[i] <= s) begin m_b[i] = 0; m_up[i] = 1'b1; end
                else m_b[i] = m_b[i] - s;
            end
        end
    endtask

    task automatic model_edge();
        int  prev;
        bit  tick;
        if (rst) begin
            m_left = 0; m_n = 0; m_ovr = 1'b0;
            for (int i = 0; i < 2; i++) begin m_a[i] = 0; m_b[i] = 0; m_up[i] = 1'b1; end
        end else begin
            m_n++;
            tick = (m_n % UDIV) == 0;
            prev = m_left;
            if (m_left == 2 && rdy) m_left = 1;
            else if (m_left == 1 && rdy) begin m_left = 0; advance_ramps(); end
            if (tick) begin
                if (prev != 0) m_ovr = 1'b1;
                else if (en) m_left = 2;
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            logic v, c, o;
            logic [W-1:0] d;
            int exp_d;
            v = (i == 0) ? valid0 : valid1;
            c = (i == 0) ? chan0 : chan1;
            o = (i == 0) ? ovr0 : ovr1;
            d = (i == 0) ? data0 : data1;
            check($sformatf("dut%0d valid", i), v, (m_left != 0));
            check($sformatf("dut%0d overrun", i), o, m_ovr);
            if (m_left != 0) begin
                exp_d = (m_left == 2) ? code_of(i, m_a[i], 1'b0) : code_of(i, m_b[i], 1'b1);
                check($sformatf("dut%0d channel", i), c, (m_left == 1));
                check($sformatf("dut%0d data", i), d, exp_d);
            end
            if (rst) check($sformatf("dut%0d reset data", i), d, 0);
        end
        if (valid0 && first_valid < 0) first_valid = m_n;
    endtask

    // Called at a negedge with inputs already set for the coming rising edge.
    task automatic cycle();
        if (rec && rdy) begin
            if (valid0) begin if (chan0) gb0.push_back(int'(data0)); else ga0.push_back(int'(data0)); end
            if (valid1) begin if (chan1) gb1.push_back(int'(data1)); else ga1.push_back(int'(data1)); end
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic wait_left(input int target, input int budget);
        int k;
        k = 0;
        while (m_left != target && k < budget) begin cycle(); k++; end
        tests++;
        assert (m_left == target) else begin
            fails++;
            $error("FAIL wait_state: reached %0d required %0d", m_left, target);
        end
    endtask

    task automatic check_seq(input string tag, input int got[$], input int exp[]);
        for (int k = 0; k < exp.size(); k++)
            check($sformatf("%s[%0d]", tag, k), (k < got.size()) ? got[k] : -1, exp[k]);
    endtask

    initial begin
        int ea0[], eb0[], ea1[], eb1[];
        ea0 = new[17];
        eb0 = new[17];
        for (int k = 0; k < 17; k++) begin
            ea0[k] = (k < 16) ? k : 0;
            eb0[k] = (k < 16) ? k : 14;
        end
        // Step 3, A signed: accA 0,3,6,9,12,15,2 coded with MSB flipped.
        ea1 = '{8, 11, 14, 1, 4, 7, 10};
        eb1 = '{0, 3, 6, 9, 12, 15, 12, 9, 6, 3, 0, 3};

        rst = 1'b1; en = 1'b1; rdy = 1'b1;
        @(negedge clk);
        repeat (3) cycle();

        // Free-running pairs with ready held high.
        rst = 1'b0; rec = 1'b1; first_valid = -1;
        repeat (140) cycle();
        rec = 1'b0;
        check("first valid edge after release", first_valid, UDIV);
        check_seq("saw step1 A", ga0, ea0);
        check_seq("tri step1 B", gb0, eb0);
        check_seq("saw step3 signed A", ga1, ea1);
        check_seq("tri step3 B", gb1, eb1);

        // Backpressure on A for 5 cycles.
        wait_left(0, 40);
        wait_left(2, 40);
        rdy = 1'b0;
        repeat (5) cycle();
        rdy = 1'b1;
        repeat (3) cycle();

        // Long stall on B produces a dropped tick.
        wait_left(1, 40);
        rdy = 1'b0;
        repeat (20) cycle();
        check("overrun after stall", ovr0, 1);
        rdy = 1'b1;
        repeat (30) cycle();

        // Randomized ready and enable.
        for (int k = 0; k < 800; k++) begin
            rdy = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 15) != 0);
            cycle();
        end

        // Enable dropped mid-pair: the pair completes, then nothing new.
        en = 1'b1; rdy = 1'b1;
        wait_left(2, 40);
        en = 1'b0;
        repeat (30) cycle();
        check("no valid after disable", valid0, 0);

        // Reset while B is on the bus.
        en = 1'b1;
        wait_left(1, 40);
        rdy = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        check("reset aborts valid", valid0, 0);
        check("reset clears overrun", ovr0, 0);
        rst = 1'b0; rdy = 1'b1;
        wait_left(2, 40);
        check("post-reset A unsigned", data0, 0);
        check("post-reset A signed", data1, 8);
        wait_left(1, 4);
        check("post-reset B", data1, 0);
        repeat (20) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
